quant_frame_decoder: RTL and testbench

- Receive-side counterpart of the scaler/quantizer chain: unpacks framed, packed quantized I/Q codes back into reconstructed 32-bit samples.
- Each 10 ms frame is one header word followed by payload words.
- The block applies the per-frame shift, saturates, and emits one sample per handshake on a valid/ready output stream.
- Sits at the far end of the link, ahead of the sample sink.

---
 rtl/quant_frame_decoder_if.sv | 23 ++
 rtl/quant_frame_decoder.sv | 158 +++++++++++++++
 tb/tb_quant_frame_decoder.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quant_frame_decoder_if.sv
// Handshake bundle for quant_frame_decoder: framed word input, sample stream output,
// frame strobe and error pulse. The decoder uses the slave modport, its driver the master.
interface quant_frame_decoder_if;
  logic        sync_10ms;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        frame_err;

  modport master (
    output sync_10ms, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_err
  );

  modport slave (
    input  sync_10ms, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_err
  );
endinterface

// File: rtl/quant_frame_decoder.sv
// quant_frame_decoder: unpacks framed, packed I/Q quantized codes into 32-bit
// {I,Q} samples, applying the per-frame left shift and a 16-bit reduction.
// Optional feature macro: QDEC_SATURATE_EN (defined: clamp to int16 range;
// undefined: keep the low 16 bits).
module quant_frame_decoder #(
  parameter int unsigned QUANT_BW = 8
) (
  input logic clk,
  input logic rst,
  quant_frame_decoder_if.slave bus
);

  localparam int unsigned LANE_W = 2 * QUANT_BW;
  localparam int unsigned LPW    = 32 / LANE_W;
  localparam int unsigned LL_W   = $clog2(LPW + 1);
  localparam logic [7:0]  MARKER = 8'hA5;

  typedef enum logic {HUNT = 1'b0, UNPACK = 1'b1} state_t;

  state_t            state, nextState;
  logic [LL_W-1:0]   lanesLeft, lanesLeftNxt;
  logic [15:0]       samplesLeft, samplesLeftNxt;
  logic [3:0]        shift, shiftNxt;
  logic [31:0]       laneBuf, laneBufNxt;
  logic [31:0]       outData, outDataNxt;
  logic              outValid, outValidNxt;
  logic              outLast, outLastNxt;
  logic              frameErr, frameErrNxt;
  logic              inReady, inReadyNxt;

  logic              inAccept, outFree, headerOk, laneMove, finalMove, abort;
  logic [QUANT_BW-1:0] laneI, laneQ;
  logic              unusedRsvd;

  // Sign-extend a code, shift it left by the frame shift, reduce to 16 bits.
  function automatic logic [15:0] recon(input logic [QUANT_BW-1:0] code, input logic [3:0] s);
`ifdef QDEC_SATURATE_EN
    logic signed [31:0] wide;
    wide = 32'(signed'(code));
    wide = wide <<< s;
    if (wide > 32'sd32767)        recon = 16'h7FFF;
    else if (wide < -32'sd32768)  recon = 16'h8000;
    else                          recon = wide[15:0];
`else
    logic [15:0] narrow;
    narrow = 16'(signed'(code));
    recon  = narrow << s;
`endif
  endfunction

  // Handshake and transfer qualifiers.
  assign inAccept   = bus.in_valid && inReady;
  assign outFree    = !outValid || bus.out_ready;
  assign headerOk   = (bus.in_data[31:24] == MARKER);
  assign laneMove   = (state == UNPACK) && (lanesLeft != '0) && outFree;
  assign finalMove  = laneMove && (samplesLeft == 16'd1);
  assign abort      = (state == UNPACK) && bus.sync_10ms && !finalMove;
  assign laneI      = laneBuf[LANE_W-1:QUANT_BW];
  assign laneQ      = laneBuf[QUANT_BW-1:0];
  assign unusedRsvd = ^bus.in_data[19:16];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= nextState;
  end

  // FSM next-state: header with nonzero count opens a frame; last sample or strobe closes it.
  always_comb begin
    nextState = state;
    case (state)
      HUNT:    if (inAccept && headerOk && (bus.in_data[15:0] != 16'd0)) nextState = UNPACK;
      UNPACK:  if (finalMove || abort) nextState = HUNT;
      default: nextState = HUNT;
    endcase
  end

  // Datapath and output next values: header latch, lane buffer, output register, error pulse.
  always_comb begin
    shiftNxt       = shift;
    samplesLeftNxt = samplesLeft;
    lanesLeftNxt   = lanesLeft;
    laneBufNxt     = laneBuf;
    outDataNxt     = outData;
    outValidNxt    = outValid;
    outLastNxt     = outLast;
    frameErrNxt    = 1'b0;
    case (state)
      HUNT: begin
        if (inAccept && headerOk) begin
          if (bus.in_data[15:0] == 16'd0) begin
            frameErrNxt = 1'b1;
          end else begin
            shiftNxt       = bus.in_data[23:20];
            samplesLeftNxt = bus.in_data[15:0];
            lanesLeftNxt   = '0;
          end
        end
      end
      UNPACK: begin
        if (abort) begin
          lanesLeftNxt   = '0;
          samplesLeftNxt = 16'd0;
          frameErrNxt    = 1'b1;
        end else if (inAccept) begin
          laneBufNxt   = bus.in_data;
          lanesLeftNxt = LL_W'(LPW);
        end else if (laneMove) begin
          laneBufNxt     = laneBuf >> LANE_W;
          lanesLeftNxt   = finalMove ? '0 : lanesLeft - LL_W'(1);
          samplesLeftNxt = samplesLeft - 16'd1;
        end
      end
      default: ;
    endcase
    if (laneMove && !abort) begin
      outDataNxt  = {recon(laneI, shift), recon(laneQ, shift)};
      outValidNxt = 1'b1;
      outLastNxt  = finalMove;
    end else if (outValid && bus.out_ready) begin
      outValidNxt = 1'b0;
      outLastNxt  = 1'b0;
    end
    inReadyNxt = (nextState == HUNT) || (lanesLeftNxt == '0);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift       <= '0;
      samplesLeft <= '0;
      lanesLeft   <= '0;
      laneBuf     <= '0;
      outData     <= '0;
      outValid    <= 1'b0;
      outLast     <= 1'b0;
      frameErr    <= 1'b0;
      inReady     <= 1'b0;
    end else begin
      shift       <= shiftNxt;
      samplesLeft <= samplesLeftNxt;
      lanesLeft   <= lanesLeftNxt;
      laneBuf     <= laneBufNxt;
      outData     <= outDataNxt;
      outValid    <= outValidNxt;
      outLast     <= outLastNxt;
      frameErr    <= frameErrNxt;
      inReady     <= inReadyNxt;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_data  = outData;
  assign bus.out_valid = outValid;
  assign bus.out_last  = outLast;
  assign bus.frame_err = frameErr;

endmodule

// File: tb/tb_quant_frame_decoder.sv
// Self-checking bench for quant_frame_decoder (QUANT_BW=8).
module tb_quant_frame_decoder;

  localparam int QB  = 8;
  localparam int LPW = 32 / (2 * QB);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quant_frame_decoder_if bus();
  quant_frame_decoder #(.QUANT_BW(QB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int errCount = 0;
  logic [32:0] recvQ[$];
  int          recvCyc[$];
  logic [32:0] expQ[$];

  // Edge counter and output/error monitor.
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      recvQ.push_back({bus.out_last, bus.out_data});
      recvCyc.push_back(cyc);
    end
    if (!rst && bus.frame_err) errCount++;
  end

  // Reference: component value = code * 2^S, then clamp or wrap to 16 bits.
  function automatic logic [15:0] modelComp(input longint code, input int s);
    longint v;
    v = code * (longint'(1) << s);
`ifdef QDEC_SATURATE_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return 16'(((v % 65536) + 65536) % 65536);
  endfunction

  function automatic logic [31:0] modelSample(input logic [31:0] w, input int lane, input int s);
    longint half, lb, ic, qc;
    half = longint'(1) << QB;
    lb = (longint'(w) >> (lane * 2 * QB)) % (half * half);
    ic = lb / half;
    qc = lb % half;
    if (ic >= half / 2) ic -= half;
    if (qc >= half / 2) qc -= half;
    return {modelComp(ic, s), modelComp(qc, s)};
  endfunction

  function automatic logic [31:0] mkHdr(input int s, input int n);
    return {8'hA5, 4'(s), 4'($urandom), 16'(n)};
  endfunction

  task automatic buildExp(input int s, input int n, input logic [31:0] pay[$]);
    expQ.delete();
    for (int i = 0; i < n; i++)
      expQ.push_back({(i == n - 1), modelSample(pay[i / LPW], i % LPW, s)});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one word from posedge+1 until accepted; returns at posedge+1 after acceptance.
  task automatic sendWord(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [31:0] hdr, input logic [31:0] pay[$], output bit ok);
    bit o;
    sendWord(hdr, o);
    ok = o;
    foreach (pay[i]) begin sendWord(pay[i], o); ok &= o; end
  endtask

  task automatic waitRecv(input int target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (recvQ.size() >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.sync_10ms = 1'b0; bus.out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++;
    if ({bus.out_valid, bus.out_last, bus.frame_err, bus.out_data} !== 35'd0) begin
      failures++; $display("FAIL reset_outputs got=%b%b%b_%h exp=000_00000000", bus.out_valid, bus.out_last, bus.frame_err, bus.out_data);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", bus.in_ready); end
    tick();
  endtask

  task automatic test_spec_vector();
    bit ok, ok2;
    int base = recvQ.size();
    int e0 = errCount;
    bus.out_ready = 1'b1;
    sendWord(32'hA5300002, ok);
    sendWord(32'h7F800102, ok2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!(bus.out_valid === 1'b1 && bus.out_data === 32'h00080010)) begin
      failures++; $display("FAIL spec_latency got=%b/%h exp=1/00080010", bus.out_valid, bus.out_data);
    end
    waitRecv(base + 2, ok);
    checks++;
    if (!ok || recvQ.size() != base + 2) begin failures++; $display("FAIL spec_count got=%0d exp=2", recvQ.size() - base); end
    else begin
      checks++;
      if (recvQ[base] !== {1'b0, 32'h00080010}) begin failures++; $display("FAIL spec_s0 got=%h exp=000080010", recvQ[base]); end
      checks++;
      if (recvQ[base+1] !== {1'b1, 32'h03F8FC00}) begin failures++; $display("FAIL spec_s1 got=%h exp=103F8FC00", recvQ[base+1]); end
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || errCount != e0) begin
      failures++; $display("FAIL spec_hunt ready=%b errs=%0d exp ready=1 errs=0", bus.in_ready, errCount - e0);
    end
    tick();
  endtask

  task automatic test_saturation();
    bit ok;
    int base = recvQ.size();
    logic [31:0] pay[$];
    logic [32:0] expv;
`ifdef QDEC_SATURATE_EN
    expv = {1'b1, 32'h7FFF8000};
`else
    expv = {1'b1, 32'hFE000000};
`endif
    bus.out_ready = 1'b1;
    pay.push_back(32'h00007F80);
    sendFrame(32'hA5900001, pay, ok);
    waitRecv(base + 1, ok);
    checks++;
    if (!ok || recvQ[base] !== expv) begin failures++; $display("FAIL saturation got=%h exp=%h", ok ? recvQ[base] : 33'd0, expv); end
  endtask

  task automatic test_bad_marker();
    bit ok, ok2;
    int base = recvQ.size();
    int e0 = errCount;
    bus.out_ready = 1'b1;
    sendWord(32'h12300005, ok);
    sendWord(32'hA5000000, ok2);
    repeat (6) tick();
    checks++;
    if (recvQ.size() != base) begin failures++; $display("FAIL badmarker_output got=%0d exp=0", recvQ.size() - base); end
    checks++;
    if (errCount - e0 != 1) begin failures++; $display("FAIL badmarker_err got=%0d exp=1", errCount - e0); end
    sendWord(32'hA5000000, ok);
    sendWord(32'hA5F00000, ok2);
    repeat (4) tick();
    checks++;
    if (errCount - e0 != 3) begin failures++; $display("FAIL consecutive_err got=%0d exp=3", errCount - e0); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base = recvQ.size();
    int s = $urandom_range(0, 15);
    int hdrCyc, span;
    logic [31:0] pay[$];
    for (int i = 0; i < 3; i++) pay.push_back($urandom);
    buildExp(s, 3 * LPW, pay);
    bus.out_ready = 1'b1;
    sendWord(mkHdr(s, 3 * LPW), ok);
    hdrCyc = cyc;
    foreach (pay[i]) sendWord(pay[i], ok);
    waitRecv(base + 3 * LPW, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", recvQ.size() - base, 3 * LPW); end
    else begin
      for (int i = 0; i < 3 * LPW; i++) begin
        checks++;
        if (recvQ[base+i] !== expQ[i]) begin failures++; $display("FAIL b2b_s%0d got=%h exp=%h", i, recvQ[base+i], expQ[i]); end
      end
      checks++;
      if (recvCyc[base] - hdrCyc != 2) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=2", recvCyc[base] - hdrCyc); end
      span = 2 * (LPW + 1) + LPW - 1;
      checks++;
      if (recvCyc[base + 3*LPW - 1] - recvCyc[base] != span) begin
        failures++; $display("FAIL b2b_throughput got=%0d exp=%0d", recvCyc[base + 3*LPW - 1] - recvCyc[base], span);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int base = recvQ.size();
    int s = $urandom_range(0, 15);
    logic [31:0] pay[$];
    pay.push_back($urandom); pay.push_back($urandom);
    buildExp(s, 4, pay);
    bus.out_ready = 1'b0;
    sendWord(mkHdr(s, 4), ok);
    sendWord(pay[0], ok);
    bus.in_data = pay[1];
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        checks++;
        if (!(bus.out_valid === 1'b1 && bus.out_data === expQ[0][31:0] && bus.out_last === 1'b0)) begin
          failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", k, bus.out_valid, bus.out_data, expQ[0][31:0]);
        end
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d got=%b exp=0", k, bus.in_ready); end
    end
    tick();
    bus.out_ready = 1'b1;
    sendWord(pay[1], ok);
    waitRecv(base + 4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_count got=%0d exp=4", recvQ.size() - base); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (recvQ[base+i] !== expQ[i]) begin failures++; $display("FAIL bp_s%0d got=%h exp=%h", i, recvQ[base+i], expQ[i]); end
    end
  endtask

  task automatic test_truncation();
    bit ok;
    int base = recvQ.size();
    int e0 = errCount;
    int s = $urandom_range(0, 15);
    logic [31:0] pay[$];
    logic [32:0] e2;
    for (int i = 0; i < 6 / LPW - 1; i++) pay.push_back($urandom);
    buildExp(s, 6, pay);
    bus.out_ready = 1'b1;
    sendFrame(mkHdr(s, 6), pay, ok);
    waitRecv(base + 4, ok);
    bus.sync_10ms = 1'b1;
    tick();
    bus.sync_10ms = 1'b0;
    repeat (4) tick();
    checks++;
    if (recvQ.size() != base + 4) begin failures++; $display("FAIL trunc_count got=%0d exp=4", recvQ.size() - base); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (recvQ[base+i] !== expQ[i]) begin failures++; $display("FAIL trunc_s%0d got=%h exp=%h", i, recvQ[base+i], expQ[i]); end
    end
    checks++;
    if (errCount - e0 != 1) begin failures++; $display("FAIL trunc_err got=%0d exp=1", errCount - e0); end
    pay.delete(); pay.push_back($urandom);
    buildExp(s, 1, pay);
    e2 = expQ[0];
    sendFrame(mkHdr(s, 1), pay, ok);
    waitRecv(base + 5, ok);
    checks++;
    if (!ok || recvQ[base+4] !== e2 || errCount - e0 != 1) begin
      failures++; $display("FAIL trunc_next got=%h exp=%h errs=%0d", ok ? recvQ[base+4] : 33'd0, e2, errCount - e0);
    end
  endtask

  task automatic test_sync_edges();
    bit ok;
    int base = recvQ.size();
    int e0 = errCount;
    int s = $urandom_range(0, 15);
    logic [31:0] pay[$];
    bus.out_ready = 1'b1;
    bus.sync_10ms = 1'b1;
    tick();
    bus.sync_10ms = 1'b0;
    pay.push_back($urandom);
    buildExp(s, 1, pay);
    sendWord(mkHdr(s, 1), ok);
    sendWord(pay[0], ok);
    bus.sync_10ms = 1'b1;
    tick();
    bus.sync_10ms = 1'b0;
    waitRecv(base + 1, ok);
    checks++;
    if (!ok || recvQ[base] !== expQ[0]) begin failures++; $display("FAIL sync_final got=%h exp=%h", ok ? recvQ[base] : 33'd0, expQ[0]); end
    checks++;
    if (errCount != e0) begin failures++; $display("FAIL sync_final_err got=%0d exp=0", errCount - e0); end
    sendWord(mkHdr(s, 4), ok);
    bus.sync_10ms = 1'b1;
    sendWord($urandom, ok);
    bus.sync_10ms = 1'b0;
    repeat (5) tick();
    checks++;
    if (recvQ.size() != base + 1 || errCount - e0 != 1) begin
      failures++; $display("FAIL sync_payload got samples=%0d errs=%0d exp samples=0 errs=1", recvQ.size() - base - 1, errCount - e0);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL sync_hunt_ready got=%b exp=1", bus.in_ready); end
    tick();
  endtask

  task automatic test_random_frames();
    int e0 = errCount;
    for (int f = 0; f < 25; f++) begin
      bit okS, okR;
      int base = recvQ.size();
      int s = $urandom_range(0, 15);
      int n = $urandom_range(1, 10);
      logic [31:0] pay[$];
      logic [31:0] junk;
      for (int i = 0; i < (n + LPW - 1) / LPW; i++) pay.push_back($urandom);
      buildExp(s, n, pay);
      if ($urandom_range(0, 1) == 1) begin
        junk = $urandom;
        if (junk[31:24] == 8'hA5) junk[31:24] = 8'h5A;
        sendWord(junk, okS);
      end
      okR = 1'b0;
      fork
        sendFrame(mkHdr(s, n), pay, okS);
        for (int c = 0; c < 800; c++) begin
          if (recvQ.size() >= base + n) begin okR = 1'b1; break; end
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      join
      checks++;
      if (!okR || !okS) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", f, recvQ.size() - base, n); end
      else for (int i = 0; i < n; i++) begin
        checks++;
        if (recvQ[base+i] !== expQ[i]) begin failures++; $display("FAIL rand%0d_s%0d got=%h exp=%h", f, i, recvQ[base+i], expQ[i]); end
      end
    end
    checks++;
    if (errCount != e0) begin failures++; $display("FAIL rand_err got=%0d exp=0", errCount - e0); end
    bus.out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    int base;
    bus.out_ready = 1'b0;
    sendWord(mkHdr(3, 4), ok);
    sendWord($urandom, ok);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rstmid_valid got=0 exp=1"); end
    tick();
    base = recvQ.size();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_cleared got valid=%b ready=%b exp 0/0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.out_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (recvQ.size() != base) begin failures++; $display("FAIL rstmid_lost got=%0d exp=0", recvQ.size() - base); end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_saturation();
    test_bad_marker();
    test_back_to_back();
    test_backpressure();
    test_truncation();
    test_sync_edges();
    test_random_frames();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
